mem_axi_wr: RTL and testbench
=============================

# mem_axi_wr

Write-data unpacker for the memory transfer interface TX path. It takes AXI slave write-data beats from the AXI4 slave controller and serialises the enabled byte lanes into a 16-bit little-endian halfword stream for the write engine. It is the write-side counterpart of the read-data packer.

## Interface
Parameters:
- SLV_AXI_DATA_WIDTH, 32: AXI data width; legal values are 32, 64 and 128. NB = SLV_AXI_DATA_WIDTH/8.
- MEM_FIFO_DATA_WIDTH, 16: write-engine word width. Fixed at 16.

Ports:
- mem_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- wr_start  in  1  pulse; latches transfer parameters; ignored unless IDLE
- wr_addr_lsb  in  4  start address bits [3:0]
- wr_xfer_axi_len  in  8  AXI len; beats = len+1
- wr_xfer_btype  in  2  0 FIXED, 1 INCR, 2 WRAP
- wr_xfer_bsize  in  3  bytes per beat = 1<<bsize; never exceeds NB
- wr_err  in  1  sampled with wr_start; discards the whole transfer
- mem_illegal_instrn_err  in  1  level; aborts output and drains
- slv_mem_wdata_valid  in  1  beat valid
- slv_mem_wdata  in  SLV_AXI_DATA_WIDTH  beat data
- slv_mem_wstrb  in  NB  byte strobes
- slv_mem_wlast  in  1  AXI wlast
- mem_slv_wdata_ack  out  1  beat accepted this cycle
- mem_16bit_wdata_valid  out  1  halfword valid
- mem_16bit_wdata  out  16  halfword; earlier stream byte in [7:0]
- mem_16bit_wdata_last  out  1  halfword carries the final byte
- mem_16bit_wdata_ack  in  1  write-engine accept
- wr_done  out  1  pulse; transfer complete
- wr_len_err  out  1  pulse; wlast mismatch

## Operation
FSM has four states: IDLE, LOAD, SHIFT, DRAIN.
- IDLE + wr_start: latch params, reset beat_cnt, clear carry. Go to DRAIN if wr_err is set, otherwise LOAD.
- LOAD: assert mem_slv_wdata_ack when valid. Register the beat and its strobes, then go to SHIFT.
- Lane selection:
  - sz = 1<<bsize; off = addr mod sz.
  - Beat 0 covers lanes [lsb mod NB, +sz-off).
  - Each later beat covers lanes [aligned lane, +sz). The aligned lane advances by sz modulo NB for INCR and WRAP, and stays fixed for FIXED.
- Bytes with strobe 0 are replaced by PAD_BYTE 8'hFF.
- SHIFT: pair the selected bytes in stream order into halfwords.
  - An odd leftover byte is kept in carry and combined with the first byte of the next beat.
  - On the final beat, an odd leftover is emitted as {8'hFF, byte} with last=1.
- Beat reload: ack = valid && (LOAD || (SHIFT && the final halfword of the beat handshakes this cycle && more beats remain)).
- After the final halfword of beat len is acked: go to IDLE and pulse wr_done.
- wlast check:
  - wlast=1 on any beat before beat len: pulse wr_len_err and continue.
  - wlast=0 on beat len: pulse wr_len_err; the transfer still ends.
- mem_illegal_instrn_err in LOAD or SHIFT: drop valid the next cycle and enter DRAIN.
- DRAIN: ack every valid beat and produce no output. After len+1 total beats, go to IDLE and pulse wr_done.

## Timing
- Reset value of every output is 0. FSM resets to IDLE; carry and counters reset to 0.
- First halfword valid appears the cycle after the beat ack.
- A 32-bit full-size beat takes 2 output cycles. Back-to-back beats have no bubble.
- mem_16bit_wdata, valid and last hold stable until ack.
- wr_done asserts 1 cycle after the final handshake.
- beat_cnt is 9 bits and does not wrap at len=255.
- The slv_mem_wdata_ack path from mem_16bit_wdata_ack is combinational. It is the only such path.
- reset_n low mid-transfer clears everything. A beat left pending upstream is not the block's responsibility.

## Structure
- Package mem_axi_wr_pkg holds:
  - state encoding
  - BTYPE_FIXED, BTYPE_INCR, BTYPE_WRAP
  - PAD_BYTE
- Sub-module wbeat_lane_sel is combinational. Inputs are lane base, sz, off, beat index and strobes. Outputs are start lane, byte count and the masked, padded byte vector.

## Test plan
- W=32, INCR, bsize=2, lsb=0, len=1, beats 0x44332211 and 0x88776655, strb=F:
  - halfwords 0x2211, 0x4433, 0x6655, 0x8877
  - last on the 4th
  - wr_done 1 cycle later
- lsb=1, bsize=2, len=0, beat 0x44332211: halfwords 0x3322 then 0xFF44 with last=1.
- FIXED, bsize=0, lsb=2, len=3, bytes A0..A3 on lane 2: halfwords 0xA1A0 then 0xA3A2 with last=1.
- strb=4'b1101, data 0x44332211, len=0: halfwords 0xFF11 then 0x4433. Additionally, hold ack low 3 cycles and check the data stays stable.
- wr_err with wr_start, len=2: 3 beats acked, valid never asserts, wr_done after the 3rd ack.
- len=3 with wlast=1 on beat 1: wr_len_err pulses once, all 4 beats are unpacked, wr_done after the 8th halfword. Separately, mem_illegal_instrn_err mid-beat drains the remaining beats.

Source files
------------

// File: rtl/mem_axi_wr_pkg.sv
// Shared types and constants for the TX write-data unpacker.
// Imported by the lane selector and the unpacker top.
package mem_axi_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] BTYPE_FIXED = 2'd0;
  localparam logic [1:0] BTYPE_INCR  = 2'd1;
  localparam logic [1:0] BTYPE_WRAP  = 2'd2;

  localparam logic [7:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/wbeat_lane_sel.sv
// Picks the active byte lanes of one write beat and pads
// strobed-off bytes; inactive lanes are zeroed.
module wbeat_lane_sel
  import mem_axi_wr_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [3:0]      base_i,
  input  logic [4:0]      sz_i,
  input  logic [3:0]      off_i,
  input  logic [8:0]      beat_idx_i,
  input  logic [NB-1:0]   strb_i,
  input  logic [NB*8-1:0] data_i,
  output logic [3:0]      start_o,
  output logic [4:0]      cnt_o,
  output logic [NB*8-1:0] bytes_o
);

  localparam logic [3:0] MSK = 4'(NB - 1);

  logic       first;
  logic [3:0] rel;

  always_comb begin
    first   = (beat_idx_i == 9'd0);
    start_o = first ? ((base_i + off_i) & MSK) : base_i;
    cnt_o   = first ? (sz_i - {1'b0, off_i}) : sz_i;
    bytes_o = '0;
    rel     = '0;
    for (int j = 0; j < NB; j++) begin
      rel = (4'(j) - start_o) & MSK;
      if ({1'b0, rel} < cnt_o)
        bytes_o[j*8 +: 8] = strb_i[j] ? data_i[j*8 +: 8]
                                      : PAD_BYTE;
    end
  end

endmodule

// File: rtl/mem_axi_wr.sv
// AXI write-data unpacker: serialises enabled byte lanes of
// each beat into a little-endian 16-bit halfword stream.
module mem_axi_wr
  import mem_axi_wr_pkg::*;
#(
  parameter int SLV_AXI_DATA_WIDTH  = 32,
  parameter int MEM_FIFO_DATA_WIDTH = 16
) (
  input  logic                            mem_clk,
  input  logic                            reset_n,
  input  logic                            wr_start,
  input  logic [3:0]                      wr_addr_lsb,
  input  logic [7:0]                      wr_xfer_axi_len,
  input  logic [1:0]                      wr_xfer_btype,
  input  logic [2:0]                      wr_xfer_bsize,
  input  logic                            wr_err,
  input  logic                            mem_illegal_instrn_err,
  input  logic                            slv_mem_wdata_valid,
  input  logic [SLV_AXI_DATA_WIDTH-1:0]   slv_mem_wdata,
  input  logic [SLV_AXI_DATA_WIDTH/8-1:0] slv_mem_wstrb,
  input  logic                            slv_mem_wlast,
  output logic                            mem_slv_wdata_ack,
  output logic                            mem_16bit_wdata_valid,
  output logic [MEM_FIFO_DATA_WIDTH-1:0]  mem_16bit_wdata,
  output logic                            mem_16bit_wdata_last,
  input  logic                            mem_16bit_wdata_ack,
  output logic                            wr_done,
  output logic                            wr_len_err
);

  localparam int         NB  = SLV_AXI_DATA_WIDTH / 8;
  localparam logic [3:0] MSK = 4'(NB - 1);

  state_e            state_q, state_d;
  logic [3:0]        off_q, base_q;
  logic [4:0]        sz_q;
  logic [7:0]        len_q;
  logic [1:0]        btype_q;
  logic [8:0]        beat_cnt_q, cnt_d;
  logic [NB*8-1:0]   data_q;
  logic [NB-1:0]     strb_q;
  logic [4:0]        pos_q;
  logic [7:0]        carry_q;
  logic              carry_vld_q;
  logic              done_q, done_d;
  logic              len_err_q, len_err_d;

  logic [4:0]        sz_s, szm1_s;
  logic [3:0]        start;
  logic [4:0]        cnt;
  logic [NB*8-1:0]   bytes;
  logic [8:0]        len1;
  logic              final_b, two, hw_ok;
  logic [4:0]        rem, take, rem_after;
  logic [3:0]        ln0, ln1, ln2;
  logic [7:0]        b0, b1, b2, stash;
  logic [15:0]       hw;
  logic              hw_last, out_vld, fire;
  logic              xfer_end, beat_end, drain_more, ack;

  function automatic logic [7:0] lane_byte(
    input logic [NB*8-1:0] v,
    input logic [3:0]      ln
  );
    lane_byte = 8'h00;
    for (int j = 0; j < NB; j++)
      if (4'(j) == ln) lane_byte = v[j*8 +: 8];
  endfunction

  wbeat_lane_sel #(.NB(NB)) u_sel (
    .base_i     (base_q),
    .sz_i       (sz_q),
    .off_i      (off_q),
    .beat_idx_i (beat_cnt_q - 9'd1),
    .strb_i     (strb_q),
    .data_i     (data_q),
    .start_o    (start),
    .cnt_o      (cnt),
    .bytes_o    (bytes)
  );

  always_comb begin
    sz_s    = 5'd1 << wr_xfer_bsize;
    szm1_s  = sz_s - 5'd1;
    len1    = {1'b0, len_q} + 9'd1;
    final_b = (beat_cnt_q == len1);
    rem     = cnt - pos_q;
    ln0     = (start + pos_q[3:0]) & MSK;
    ln1     = (ln0 + 4'd1) & MSK;
    ln2     = (ln0 + 4'd2) & MSK;
    b0      = lane_byte(bytes, ln0);
    b1      = lane_byte(bytes, ln1);
    b2      = lane_byte(bytes, ln2);
    two     = !carry_vld_q && (rem >= 5'd2);
    hw_ok   = carry_vld_q || two || final_b;
    take    = two ? 5'd2 : 5'd1;
    rem_after = rem - take;
    if (carry_vld_q)  hw = {b0, carry_q};
    else if (two)     hw = {b1, b0};
    else              hw = {PAD_BYTE, b0};
    hw_last  = final_b && (rem_after == 5'd0);
    out_vld  = (state_q == ST_SHIFT) && hw_ok;
    fire     = out_vld && mem_16bit_wdata_ack;
    xfer_end = fire && hw_last;
    // a lone non-final byte is parked in carry without output
    beat_end = (state_q == ST_SHIFT) &&
               (fire ? (rem_after == 5'd0 ||
                        (rem_after == 5'd1 && !final_b))
                     : !hw_ok);
    stash    = !hw_ok ? b0 : (carry_vld_q ? b1 : b2);
    drain_more = (state_q == ST_DRAIN) && (beat_cnt_q != len1);
    ack = slv_mem_wdata_valid &&
          (state_q == ST_LOAD || (beat_end && !final_b) ||
           drain_more);
    cnt_d     = beat_cnt_q + {8'd0, ack};
    len_err_d = ack &&
                (slv_mem_wlast != (beat_cnt_q == {1'b0, len_q}));
    done_d    = xfer_end ||
                (state_q == ST_DRAIN && cnt_d == len1);
  end

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (wr_start) state_d = wr_err ? ST_DRAIN : ST_LOAD;
      ST_LOAD:
        if (mem_illegal_instrn_err) state_d = ST_DRAIN;
        else if (ack)               state_d = ST_SHIFT;
      ST_SHIFT:
        if (xfer_end)                    state_d = ST_IDLE;
        else if (mem_illegal_instrn_err) state_d = ST_DRAIN;
        else if (beat_end && !ack)       state_d = ST_LOAD;
      ST_DRAIN:
        if (cnt_d == len1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_slv_wdata_ack     = ack;
    mem_16bit_wdata_valid = out_vld;
    mem_16bit_wdata       = out_vld ? hw : '0;
    mem_16bit_wdata_last  = out_vld && hw_last;
    wr_done               = done_q;
    wr_len_err            = len_err_q;
  end

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      off_q       <= '0;
      base_q      <= '0;
      sz_q        <= '0;
      len_q       <= '0;
      btype_q     <= '0;
      beat_cnt_q  <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      pos_q       <= '0;
      carry_q     <= '0;
      carry_vld_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      done_q    <= done_d;
      len_err_q <= len_err_d;
      if (state_q == ST_IDLE && wr_start) begin
        off_q       <= wr_addr_lsb & szm1_s[3:0];
        base_q      <= wr_addr_lsb & MSK & ~szm1_s[3:0];
        sz_q        <= sz_s;
        len_q       <= wr_xfer_axi_len;
        btype_q     <= wr_xfer_btype;
        beat_cnt_q  <= '0;
        pos_q       <= '0;
        carry_vld_q <= 1'b0;
      end else begin
        beat_cnt_q <= cnt_d;
        if (state_q == ST_SHIFT) begin
          if (beat_end) begin
            if (btype_q != BTYPE_FIXED)
              base_q <= (base_q + sz_q[3:0]) & MSK;
            if (!hw_ok || rem_after == 5'd1) begin
              carry_q     <= stash;
              carry_vld_q <= 1'b1;
            end else begin
              carry_vld_q <= 1'b0;
            end
          end else if (fire) begin
            pos_q       <= pos_q + take;
            carry_vld_q <= 1'b0;
          end
        end
        if (ack && state_q != ST_DRAIN) begin
          data_q <= slv_mem_wdata;
          strb_q <= slv_mem_wstrb;
          pos_q  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_axi_wr.sv
// Randomised and directed bench for mem_axi_wr against an
// address-arithmetic byte-stream reference model.
module tb_mem_axi_wr;

  localparam int W     = 32;
  localparam int NB    = W / 8;
  localparam int LIMIT = 4000;

  logic          mem_clk = 1'b0;
  logic          reset_n;
  logic          wr_start;
  logic [3:0]    wr_addr_lsb;
  logic [7:0]    wr_xfer_axi_len;
  logic [1:0]    wr_xfer_btype;
  logic [2:0]    wr_xfer_bsize;
  logic          wr_err;
  logic          mem_illegal_instrn_err;
  logic          slv_mem_wdata_valid;
  logic [W-1:0]  slv_mem_wdata;
  logic [NB-1:0] slv_mem_wstrb;
  logic          slv_mem_wlast;
  logic          mem_slv_wdata_ack;
  logic          mem_16bit_wdata_valid;
  logic [15:0]   mem_16bit_wdata;
  logic          mem_16bit_wdata_last;
  logic          mem_16bit_wdata_ack;
  logic          wr_done;
  logic          wr_len_err;

  always #5 mem_clk = ~mem_clk;

  mem_axi_wr #(.SLV_AXI_DATA_WIDTH(W), .MEM_FIFO_DATA_WIDTH(16)) dut (
    .mem_clk                (mem_clk),
    .reset_n                (reset_n),
    .wr_start               (wr_start),
    .wr_addr_lsb            (wr_addr_lsb),
    .wr_xfer_axi_len        (wr_xfer_axi_len),
    .wr_xfer_btype          (wr_xfer_btype),
    .wr_xfer_bsize          (wr_xfer_bsize),
    .wr_err                 (wr_err),
    .mem_illegal_instrn_err (mem_illegal_instrn_err),
    .slv_mem_wdata_valid    (slv_mem_wdata_valid),
    .slv_mem_wdata          (slv_mem_wdata),
    .slv_mem_wstrb          (slv_mem_wstrb),
    .slv_mem_wlast          (slv_mem_wlast),
    .mem_slv_wdata_ack      (mem_slv_wdata_ack),
    .mem_16bit_wdata_valid  (mem_16bit_wdata_valid),
    .mem_16bit_wdata        (mem_16bit_wdata),
    .mem_16bit_wdata_last   (mem_16bit_wdata_last),
    .mem_16bit_wdata_ack    (mem_16bit_wdata_ack),
    .wr_done                (wr_done),
    .wr_len_err             (wr_len_err)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  bdat [256];
  logic [NB-1:0] bstb [256];
  logic          bwl  [256];
  logic [16:0]   exp_q [$];
  logic [16:0]   obs_q [$];

  int acks, lenerrs, dones, vld_cnt, hold_viol, vld_post_err;
  int first_ack_cyc, first_vld_cyc, last_hs_cyc, last_ack_cyc;
  int done_cyc;
  bit timed_out;

  // Stream model: lane of each byte from AXI address arithmetic.
  function automatic void build_exp(input logic [3:0] lsb,
                                    input int len,
                                    input logic [1:0] bt,
                                    input logic [2:0] bs);
    logic [7:0] sb [$];
    logic [W-1:0] d;
    logic [NB-1:0] s;
    int sz, off, al, st, n, ln;
    sz  = 1 << bs;
    off = int'(lsb) % sz;
    al  = (int'(lsb) % NB) - off;
    for (int k = 0; k <= len; k++) begin
      d = bdat[k];
      s = bstb[k];
      if (k == 0) begin
        st = int'(lsb) % NB;
        n  = sz - off;
      end else begin
        st = (bt == 2'd0) ? al : (al + k * sz) % NB;
        n  = sz;
      end
      for (int i = 0; i < n; i++) begin
        ln = (st + i) % NB;
        sb.push_back(s[ln] ? d[ln*8 +: 8] : 8'hFF);
      end
    end
    exp_q.delete();
    for (int i = 0; i < sb.size(); i += 2) begin
      if (i + 1 < sb.size())
        exp_q.push_back({1'(i + 2 >= sb.size()), sb[i+1], sb[i]});
      else
        exp_q.push_back({1'b1, 8'hFF, sb[i]});
    end
  endfunction

  task automatic set_wl(input int len);
    for (int k = 0; k < 256; k++) bwl[k] = (k == len);
  endtask

  task automatic run_xfer(input logic [3:0] lsb, input int len,
                          input logic [1:0] bt, input logic [2:0] bs,
                          input bit werr, input int amode,
                          input bit vrand, input int err_after);
    int pb, cyc, stall, err_cyc;
    bit pv, holding;
    logic [16:0] held;
    obs_q.delete();
    acks = 0; lenerrs = 0; dones = 0; vld_cnt = 0;
    hold_viol = 0; vld_post_err = 0; timed_out = 0;
    first_ack_cyc = -1; first_vld_cyc = -1; last_hs_cyc = -1;
    last_ack_cyc = -1; done_cyc = -1;
    wr_start = 1; wr_addr_lsb = lsb; wr_xfer_axi_len = 8'(len);
    wr_xfer_btype = bt; wr_xfer_bsize = bs; wr_err = werr;
    @(posedge mem_clk); #1;
    wr_start = 0; wr_err = 0;
    pb = 0; pv = 0; cyc = 0; stall = 0; err_cyc = -1; holding = 0;
    held = '0;
    while (done_cyc < 0) begin
      if (cyc >= LIMIT) begin
        timed_out = 1;
        break;
      end
      if (pb <= len) begin
        if (!pv) pv = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
        slv_mem_wdata = bdat[pb];
        slv_mem_wstrb = bstb[pb];
        slv_mem_wlast = bwl[pb];
      end else begin
        pv = 0;
        slv_mem_wdata = '0; slv_mem_wstrb = '0; slv_mem_wlast = 0;
      end
      slv_mem_wdata_valid = pv;
      case (amode)
        0:       mem_16bit_wdata_ack = 1'b1;
        1:       mem_16bit_wdata_ack = ($urandom_range(0, 2) != 0);
        default: mem_16bit_wdata_ack = (stall >= 3);
      endcase
      if (err_after >= 0 && obs_q.size() >= err_after) begin
        mem_illegal_instrn_err = 1'b1;
        if (err_cyc < 0) err_cyc = cyc;
      end
      @(negedge mem_clk);
      if (mem_16bit_wdata_valid) begin
        vld_cnt++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (err_cyc >= 0 && cyc > err_cyc) vld_post_err++;
        if (holding &&
            {mem_16bit_wdata_last, mem_16bit_wdata} !== held)
          hold_viol++;
        if (mem_16bit_wdata_ack) begin
          obs_q.push_back({mem_16bit_wdata_last, mem_16bit_wdata});
          last_hs_cyc = cyc;
          holding = 0;
        end else begin
          holding = 1;
          held = {mem_16bit_wdata_last, mem_16bit_wdata};
          stall++;
        end
      end else begin
        if (holding) hold_viol++;
        holding = 0;
      end
      if (mem_slv_wdata_ack) begin
        acks++;
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
        last_ack_cyc = cyc;
        pb++;
        pv = 0;
      end
      if (wr_len_err) lenerrs++;
      if (wr_done) begin
        dones++;
        done_cyc = cyc;
      end
      @(posedge mem_clk); #1;
      cyc++;
    end
    mem_illegal_instrn_err = 0;
    slv_mem_wdata_valid = 0;
    mem_16bit_wdata_ack = 0;
    @(posedge mem_clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(posedge mem_clk);
    @(negedge mem_clk);
    total++;
    if ({mem_slv_wdata_ack, mem_16bit_wdata_valid, mem_16bit_wdata,
         mem_16bit_wdata_last, wr_done, wr_len_err} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0",
               {mem_slv_wdata_ack, mem_16bit_wdata_valid,
                mem_16bit_wdata, mem_16bit_wdata_last,
                wr_done, wr_len_err});
    end
    @(posedge mem_clk); #1;
    reset_n = 1;
    @(negedge mem_clk);
    total++;
    if ({mem_slv_wdata_ack, mem_16bit_wdata_valid, wr_done,
         wr_len_err} !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_outs: got %b want 0000",
               {mem_slv_wdata_ack, mem_16bit_wdata_valid,
                wr_done, wr_len_err});
    end
    @(posedge mem_clk); #1;
  endtask

  task automatic test_incr_basic;
    logic [16:0] want [4];
    want[0] = 17'h02211; want[1] = 17'h04433;
    want[2] = 17'h06655; want[3] = 17'h18877;
    bdat[0] = 32'h44332211; bdat[1] = 32'h88776655;
    bstb[0] = 4'hF; bstb[1] = 4'hF;
    set_wl(1);
    run_xfer(4'd0, 1, 2'd1, 3'd2, 0, 0, 0, -1);
    total++;
    if (timed_out !== 1'b0) begin
      bad++; $display("FAIL incr_timeout: got 1 want 0");
    end
    total++;
    if (obs_q.size() != 4) begin
      bad++; $display("FAIL incr_count: got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== want[i]) begin
        bad++;
        $display("FAIL incr_hw%0d: got %h want %h", i, obs_q[i], want[i]);
      end
    end
    total++;
    if (first_vld_cyc - first_ack_cyc != 1) begin
      bad++;
      $display("FAIL incr_first_lat: got %0d want 1",
               first_vld_cyc - first_ack_cyc);
    end
    total++;
    if (last_hs_cyc - first_vld_cyc != 3) begin
      bad++;
      $display("FAIL incr_no_bubble: got %0d want 3",
               last_hs_cyc - first_vld_cyc);
    end
    total++;
    if (done_cyc - last_hs_cyc != 1 || dones != 1) begin
      bad++;
      $display("FAIL incr_done: got lat %0d n %0d want 1 1",
               done_cyc - last_hs_cyc, dones);
    end
  endtask

  task automatic test_unaligned;
    bdat[0] = 32'h44332211; bstb[0] = 4'hF;
    set_wl(0);
    run_xfer(4'd1, 0, 2'd1, 3'd2, 0, 0, 0, -1);
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL unal_count: got %0d want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== 17'h03322 || obs_q[1] !== 17'h1FF44) begin
        bad++;
        $display("FAIL unal_hw: got %h %h want 03322 1ff44",
                 obs_q[0], obs_q[1]);
      end
    end
  endtask

  task automatic test_fixed;
    for (int k = 0; k < 4; k++) begin
      bdat[k] = 32'(8'hA0 + 8'(k)) << 16;
      bstb[k] = 4'b0100;
    end
    set_wl(3);
    run_xfer(4'd2, 3, 2'd0, 3'd0, 0, 1, 1, -1);
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL fixed_count: got %0d want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== 17'h0A1A0 || obs_q[1] !== 17'h1A3A2) begin
        bad++;
        $display("FAIL fixed_hw: got %h %h want 0a1a0 1a3a2",
                 obs_q[0], obs_q[1]);
      end
    end
  endtask

  task automatic test_strb_stall;
    bdat[0] = 32'h44332211; bstb[0] = 4'b1101;
    set_wl(0);
    run_xfer(4'd0, 0, 2'd1, 3'd2, 0, 2, 0, -1);
    total++;
    if (obs_q.size() != 2) begin
      bad++; $display("FAIL strb_count: got %0d want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0] !== 17'h0FF11 || obs_q[1] !== 17'h14433) begin
        bad++;
        $display("FAIL strb_hw: got %h %h want 0ff11 14433",
                 obs_q[0], obs_q[1]);
      end
    end
    total++;
    if (hold_viol != 0 || vld_cnt != 5) begin
      bad++;
      $display("FAIL strb_hold: got viol %0d vld %0d want 0 5",
               hold_viol, vld_cnt);
    end
  endtask

  task automatic test_wr_err;
    for (int k = 0; k < 3; k++) begin
      bdat[k] = $urandom; bstb[k] = 4'hF;
    end
    set_wl(2);
    run_xfer(4'd0, 2, 2'd1, 3'd2, 1, 0, 1, -1);
    total++;
    if (vld_cnt != 0 || acks != 3) begin
      bad++;
      $display("FAIL wrerr_drain: got vld %0d acks %0d want 0 3",
               vld_cnt, acks);
    end
    total++;
    if (done_cyc - last_ack_cyc != 1 || timed_out) begin
      bad++;
      $display("FAIL wrerr_done: got lat %0d to %0d want 1 0",
               done_cyc - last_ack_cyc, timed_out);
    end
  endtask

  task automatic test_wlast;
    for (int k = 0; k < 4; k++) begin
      bdat[k] = $urandom; bstb[k] = 4'hF;
    end
    set_wl(3);
    bwl[1] = 1'b1;
    build_exp(4'd0, 3, 2'd1, 3'd2);
    run_xfer(4'd0, 3, 2'd1, 3'd2, 0, 1, 1, -1);
    total++;
    if (lenerrs != 1) begin
      bad++; $display("FAIL wlast_early: got %0d want 1", lenerrs);
    end
    total++;
    if (obs_q.size() != 8 || obs_q != exp_q) begin
      bad++;
      $display("FAIL wlast_data: got n=%0d want n=8 matching model",
               obs_q.size());
    end
    total++;
    if (done_cyc - last_hs_cyc != 1) begin
      bad++;
      $display("FAIL wlast_done: got %0d want 1", done_cyc - last_hs_cyc);
    end
    set_wl(-1);
    run_xfer(4'd0, 1, 2'd1, 3'd2, 0, 0, 0, -1);
    total++;
    if (lenerrs != 1 || dones != 1) begin
      bad++;
      $display("FAIL wlast_missing: got err %0d done %0d want 1 1",
               lenerrs, dones);
    end
  endtask

  task automatic test_illegal;
    for (int k = 0; k < 4; k++) begin
      bdat[k] = $urandom; bstb[k] = 4'hF;
    end
    set_wl(3);
    build_exp(4'd0, 3, 2'd1, 3'd2);
    run_xfer(4'd0, 3, 2'd1, 3'd2, 0, 0, 0, 3);
    total++;
    if (vld_post_err != 0 || obs_q.size() >= 8) begin
      bad++;
      $display("FAIL illegal_stop: got post %0d n %0d want 0 <8",
               vld_post_err, obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL illegal_hw%0d: got %h want %h",
                 i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (acks != 4 || dones != 1 || timed_out) begin
      bad++;
      $display("FAIL illegal_drain: got acks %0d done %0d want 4 1",
               acks, dones);
    end
  endtask

  task automatic test_random;
    logic [3:0] lsb;
    logic [1:0] bt;
    logic [2:0] bs;
    int len;
    int wl [4] = '{1, 3, 7, 15};
    for (int t = 0; t < 24; t++) begin
      lsb = 4'($urandom_range(0, 15));
      bt  = 2'($urandom_range(0, 2));
      bs  = 3'($urandom_range(0, 2));
      len = (bt == 2'd2) ? wl[$urandom_range(0, 3)]
                         : $urandom_range(0, 15);
      for (int k = 0; k <= len; k++) begin
        bdat[k] = $urandom;
        bstb[k] = 4'($urandom_range(0, 15));
      end
      set_wl(len);
      build_exp(lsb, len, bt, bs);
      run_xfer(lsb, len, bt, bs, 0, 1, 1, -1);
      total++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rnd%0d_count: got %0d want %0d (to=%0d)",
                 t, obs_q.size(), exp_q.size(), timed_out);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rnd%0d_hw%0d: got %h want %h",
                   t, i, obs_q[i], exp_q[i]);
        end
      end
      total++;
      if (lenerrs != 0 || dones != 1 || done_cyc - last_hs_cyc != 1) begin
        bad++;
        $display("FAIL rnd%0d_end: got err %0d done %0d lat %0d want 0 1 1",
                 t, lenerrs, dones, done_cyc - last_hs_cyc);
      end
    end
  endtask

  task automatic test_len255;
    logic [3:0] lsb;
    lsb = 4'($urandom_range(0, 3));
    for (int k = 0; k < 256; k++) begin
      bdat[k] = $urandom; bstb[k] = 4'hF;
    end
    set_wl(255);
    build_exp(lsb, 255, 2'd1, 3'd2);
    run_xfer(lsb, 255, 2'd1, 3'd2, 0, 0, 0, -1);
    total++;
    if (timed_out || acks != 256 || obs_q != exp_q) begin
      bad++;
      $display("FAIL len255: got acks %0d n %0d want 256 %0d",
               acks, obs_q.size(), exp_q.size());
    end
    total++;
    if (lenerrs != 0 || dones != 1) begin
      bad++;
      $display("FAIL len255_end: got err %0d done %0d want 0 1",
               lenerrs, dones);
    end
  endtask

  initial begin
    reset_n = 0; wr_start = 0; wr_addr_lsb = '0; wr_xfer_axi_len = '0;
    wr_xfer_btype = '0; wr_xfer_bsize = '0; wr_err = 0;
    mem_illegal_instrn_err = 0; slv_mem_wdata_valid = 0;
    slv_mem_wdata = '0; slv_mem_wstrb = '0; slv_mem_wlast = 0;
    mem_16bit_wdata_ack = 0;
    test_reset;
    test_incr_basic;
    test_unaligned;
    test_fixed;
    test_strb_stall;
    test_wr_err;
    test_wlast;
    test_illegal;
    test_random;
    test_len255;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
